gaus_stat_meter: RTL



---
 rtl/gaus_stat_meter_if.sv | 31 +++
 rtl/gaus_stat_meter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gaus_stat_meter_if.sv
// Sample/result bundle between a complex-noise source and gaus_stat_meter.
// The master side drives the run control and samples; the slave side returns statistics.
interface gaus_stat_meter_if #(
  parameter int pDAT_W = 18,
  parameter int pLEN_W = 16
);
  localparam int SUM_W = pDAT_W + pLEN_W + 1;
  localparam int ENG_W = 2 * pDAT_W + pLEN_W;

  logic                     istart;
  logic [pLEN_W-1:0]        ilen;
  logic                     ival;
  logic signed [pDAT_W-1:0] idat_re;
  logic signed [pDAT_W-1:0] idat_im;
  logic                     obusy;
  logic                     odone;
  logic signed [SUM_W-1:0]  osum_re;
  logic signed [SUM_W-1:0]  osum_im;
  logic [ENG_W-1:0]         oenergy;
  logic [pDAT_W-1:0]        omax_abs;

  modport master (
    output istart, ilen, ival, idat_re, idat_im,
    input  obusy, odone, osum_re, osum_im, oenergy, omax_abs
  );

  modport slave (
    input  istart, ilen, ival, idat_re, idat_im,
    output obusy, odone, osum_re, osum_im, oenergy, omax_abs
  );
endinterface

// File: rtl/gaus_stat_meter.sv
// Run-based statistics meter for complex Gaussian samples: per-rail sums, total
// energy and peak magnitude over N samples, held in output registers until the next run.
module gaus_stat_meter #(
  parameter int pDAT_W = 18,
  parameter int pLEN_W = 16
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  gaus_stat_meter_if.slave  bus
);
  localparam int SUM_W = pDAT_W + pLEN_W + 1;
  localparam int SQ_W  = 2 * pDAT_W;
  localparam int ENG_W = 2 * pDAT_W + pLEN_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Magnitude as unsigned: the most negative code maps to 2^(pDAT_W-1), which still fits.
  function automatic logic [pDAT_W-1:0] abs_f(input logic signed [pDAT_W-1:0] x);
    logic [pDAT_W-1:0] r;
    if (x[pDAT_W-1]) begin
      r = ~x + pDAT_W'(1);
    end else begin
      r = x;
    end
    return r;
  endfunction

  function automatic logic [pDAT_W-1:0] max_f(input logic [pDAT_W-1:0] a,
                                              input logic [pDAT_W-1:0] b);
    logic [pDAT_W-1:0] r;
    if (a > b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

  state_t              state_r, state_s;
  logic                start_s, accept_s;
  logic [pLEN_W-1:0]   cnt_r, last_idx_r;
  logic                flush_cnt_r;

  logic                     s1_vld_r;
  logic signed [pDAT_W-1:0] s1_re_r, s1_im_r;
  logic [pDAT_W-1:0]        abs_re_s, abs_im_s;

  logic                     s2_vld_r;
  logic signed [pDAT_W-1:0] s2_re_r, s2_im_r;
  logic [SQ_W-1:0]          s2_sq_re_r, s2_sq_im_r;
  logic [pDAT_W-1:0]        s2_max_r;

  logic signed [SUM_W-1:0]  acc_re_r, acc_im_r;
  logic [ENG_W-1:0]         acc_eng_r;
  logic [pDAT_W-1:0]        acc_max_r;

  logic                     obusy_r, odone_r;
  logic signed [SUM_W-1:0]  osum_re_r, osum_im_r;
  logic [ENG_W-1:0]         oenergy_r;
  logic [pDAT_W-1:0]        omax_abs_r;

  // Next-state decode; start/accept strobes are only acted on at enabled edges.
  always_comb begin
    state_s  = state_r;
    start_s  = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.istart) begin
          start_s = 1'b1;
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.ival) begin
          accept_s = 1'b1;
          if (cnt_r == last_idx_r) begin
            state_s = ST_FLUSH;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control registers: state, sample counter, flush counter, busy flag.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {pLEN_W{1'b0}};
      last_idx_r  <= {pLEN_W{1'b0}};
      flush_cnt_r <= 1'b0;
      obusy_r     <= 1'b0;
    end else if (iclkena) begin
      state_r <= state_s;
      obusy_r <= (state_s == ST_RUN) || (state_s == ST_FLUSH);
      if (start_s) begin
        // ilen=0 wraps to all-ones, giving a full 2^pLEN_W run.
        last_idx_r <= bus.ilen - pLEN_W'(1);
        cnt_r      <= {pLEN_W{1'b0}};
      end else if (accept_s) begin
        cnt_r <= cnt_r + pLEN_W'(1);
      end
      if (state_r == ST_FLUSH) begin
        flush_cnt_r <= ~flush_cnt_r;
      end else begin
        flush_cnt_r <= 1'b0;
      end
    end
  end

  assign abs_re_s = abs_f(s1_re_r);
  assign abs_im_s = abs_f(s1_im_r);

  // Three-stage datapath: capture, square/magnitude, accumulate.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      s1_vld_r   <= 1'b0;
      s1_re_r    <= {pDAT_W{1'b0}};
      s1_im_r    <= {pDAT_W{1'b0}};
      s2_vld_r   <= 1'b0;
      s2_re_r    <= {pDAT_W{1'b0}};
      s2_im_r    <= {pDAT_W{1'b0}};
      s2_sq_re_r <= {SQ_W{1'b0}};
      s2_sq_im_r <= {SQ_W{1'b0}};
      s2_max_r   <= {pDAT_W{1'b0}};
      acc_re_r   <= {SUM_W{1'b0}};
      acc_im_r   <= {SUM_W{1'b0}};
      acc_eng_r  <= {ENG_W{1'b0}};
      acc_max_r  <= {pDAT_W{1'b0}};
    end else if (iclkena) begin
      s1_vld_r <= accept_s;
      if (accept_s) begin
        s1_re_r <= bus.idat_re;
        s1_im_r <= bus.idat_im;
      end
      s2_vld_r   <= s1_vld_r && !start_s;
      s2_re_r    <= s1_re_r;
      s2_im_r    <= s1_im_r;
      s2_sq_re_r <= SQ_W'(abs_re_s) * SQ_W'(abs_re_s);
      s2_sq_im_r <= SQ_W'(abs_im_s) * SQ_W'(abs_im_s);
      s2_max_r   <= max_f(abs_re_s, abs_im_s);
      if (start_s) begin
        acc_re_r  <= {SUM_W{1'b0}};
        acc_im_r  <= {SUM_W{1'b0}};
        acc_eng_r <= {ENG_W{1'b0}};
        acc_max_r <= {pDAT_W{1'b0}};
      end else if (s2_vld_r) begin
        acc_re_r  <= acc_re_r + SUM_W'(s2_re_r);
        acc_im_r  <= acc_im_r + SUM_W'(s2_im_r);
        acc_eng_r <= acc_eng_r + ENG_W'(s2_sq_re_r) + ENG_W'(s2_sq_im_r);
        acc_max_r <= max_f(acc_max_r, s2_max_r);
      end
    end
  end

  // Result registers: loaded on the edge leaving DONE, held across later runs.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      odone_r    <= 1'b0;
      osum_re_r  <= {SUM_W{1'b0}};
      osum_im_r  <= {SUM_W{1'b0}};
      oenergy_r  <= {ENG_W{1'b0}};
      omax_abs_r <= {pDAT_W{1'b0}};
    end else if (iclkena) begin
      odone_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        osum_re_r  <= acc_re_r;
        osum_im_r  <= acc_im_r;
        oenergy_r  <= acc_eng_r;
        omax_abs_r <= acc_max_r;
      end
    end
  end

  assign bus.obusy    = obusy_r;
  assign bus.odone    = odone_r;
  assign bus.osum_re  = osum_re_r;
  assign bus.osum_im  = osum_im_r;
  assign bus.oenergy  = oenergy_r;
  assign bus.omax_abs = omax_abs_r;

endmodule
